kbd_slot: RTL
=============

# kbd_slot

Memory-mapped PS/2 keyboard responder that occupies one of the mainboard memory-selector slots reserved for the keyboard. It receives PS/2 frames, buffers scancodes in a small FIFO, and answers CPU load/store cycles on the shared 8-bit data bus through a status/data/control register set. It is the target side of the CPU's chip-select/oe_/we_ memory protocol, in place of a RAM chip.

## Interface

**Parameters**
- DEPTH, 8: FIFO entries; power of two, maximum 16.
- FILTER, 4: clk cycles ps2_clk must hold low after being high before a falling edge is accepted.
- TIMEOUT, 2048: clk cycles without an accepted falling edge before a partial frame is abandoned.

**Ports** (clock and reset first)
- clk, input, 1: system clock. Single clock domain; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- cs_, input, 1: slot select from the memory chip-select decode, active-low.
- oe_, input, 1: bus read strobe, active-low.
- we_, input, 1: bus write strobe, active-low.
- addr, input, 2: register select. 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- data, inout, 8: shared data bus. Driven only while cs_=0, oe_=0 and we_=1; high-Z otherwise.
- ps2_clk, input, 1: PS/2 clock, asynchronous to clk.
- ps2_data, input, 1: PS/2 data, asynchronous to clk.
- kbd_irq_, output, 1: active-low; 0 while the FIFO is non-empty and CTRL.en = 1.

## Operation

**Input synchronisation and edge filter**
- ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- A falling edge is accepted when synchronised ps2_clk has been 1 and then reads 0 for FILTER consecutive cycles.

**Receive FSM** (one transition per accepted edge)
- IDLE: a sampled data bit of 0 is a start bit and moves to DATA; a 1 stays in IDLE.
- DATA: shifts 8 bits in, LSB first; moves to PARITY after bit 7.
- PARITY: checks odd parity over data plus the parity bit.
- STOP: a stop bit of 1 with good parity pushes the byte. Otherwise the byte is discarded and perr is set. Either way the FSM returns to IDLE.
- TIMEOUT cycles with no accepted edge outside IDLE force IDLE, with no push and no error.
- While CTRL.en = 0 the FSM is held in IDLE.

**FIFO**
- DEPTH entries, head and tail pointers that wrap, count of width log2(DEPTH)+1.
- Push while full: the new byte is dropped and ovf is set.
- Push and pop in the same cycle: both take effect and count is unchanged.

**Bus reads** (read access is cs_=0 and oe_=0)
- Data is driven combinationally for the whole access.
- DATA returns the FIFO head, or 0x00 when empty.
- STATUS = {count[3:0], perr, ovf, full, !empty}, bit 0 = !empty.
- CTRL returns {7'b0, en}; reserved returns 0x00.
- A DATA read pops exactly once, on the first clk edge after the access ends. A held read never pops repeatedly.

**Bus writes** (write access is cs_=0 and we_=0)
- data is sampled every cycle of the access; the last sampled value is applied on the first clk edge after the access ends.
- CTRL bits: bit0 flush (empties FIFO), bit1 clr (clears ovf and perr), bit2 en.
- Writes to DATA, STATUS or reserved are ignored.

**Simultaneous events**
- Flush beats a same-cycle push or pop; count becomes 0.
- clr beats a same-cycle error set, so the flag ends cleared.

## Timing

**Reset values**
- FSM = IDLE, FIFO empty, count = 0, ovf = perr = 0, en = 1.
- kbd_irq_ = 1, data = high-Z.
- Reset asserted mid-frame or mid-access aborts it. No pop or write is applied on release.

**Latencies**
- Push to the FIFO occurs 1 cycle after the stop-bit edge is accepted.
- kbd_irq_ falls 1 cycle after the push.
- STATUS reflects the push in the same cycle as kbd_irq_.
- Pop takes effect 1 cycle after oe_ or cs_ deasserts; STATUS reflects it on the following read.
- Bus read data is valid one combinational (tri-state) delay after cs_ and oe_ are both low.
- Accepted-edge latency is 2 synchroniser cycles plus FILTER cycles.

## Structure

- **kbd_pkg** holds:
  - register address constants: ADDR_DATA, ADDR_STATUS, ADDR_CTRL;
  - STATUS and CTRL bit-position constants;
  - the rx_state_t enum {IDLE, DATA, PARITY, STOP}.
- **byte_fifo** is one sub-module, parameterised by DEPTH, with push/pop/flush, head, count, full and empty.
- Synchroniser, filter, FSM and bus decode live in kbd_slot.

## Test plan

- **Single frame:** reset, then one PS/2 frame carrying 0x1C with odd parity correct. Expect STATUS = 0x11 and kbd_irq_ = 0. A DATA read returns 0x1C; the next STATUS read = 0x00 and kbd_irq_ = 1.
- **Parity error:** frame 0x1C with the parity bit flipped. Expect no push and STATUS = 0x08. A CTRL write of 0x06 clears it, giving STATUS = 0x00.
- **Overflow:** 9 good frames 0x01..0x09 with DEPTH = 8. Expect STATUS = 0x87 (count 8, ovf, full, !empty). Eight DATA reads return 0x01..0x08 in order; a 9th read returns 0x00.
- **Simultaneous push/pop and held read:**
  - With 3 entries queued, end a DATA read in the same cycle a stop-bit edge is accepted. Expect count to stay 3 and FIFO order to be preserved.
  - Hold oe_ low for 20 cycles on DATA. Expect exactly one pop.
- **Timeout:** start bit plus 4 data bits, then idle for TIMEOUT+10 cycles, then a full frame 0x5A. Expect only 0x5A in the FIFO and perr = 0.
- **Flush and reset:**
  - Write CTRL = 0x05 (flush, en kept 1) with 4 entries queued. Expect count = 0.
  - Assert rst_n mid-frame, then release and send frame 0x22. Expect 0x22 received cleanly, with no stale bits.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants and types for the memory-mapped PS/2 keyboard slot.
package kbd_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_NE      = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_PERR    = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_EN    = 2;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Scancode FIFO with wrapping head/tail pointers; flush wins over push and pop.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/kbd_slot.sv
// PS/2 keyboard responder in a memory-selector slot: receive, buffer and
// serve scancodes through DATA/STATUS/CTRL registers on the shared bus.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on an accepted edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then push or flag a parity error
module kbd_slot
  import kbd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 2048
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_,
  input  logic       oe_,
  input  logic       we_,
  input  logic [1:0] addr,
  inout  wire  [7:0] data,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       kbd_irq_
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       ps2_clk_s;
  logic       ps2_data_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign ps2_clk_s  = clk_sync[1];
  assign ps2_data_s = dat_sync[1];

  // Low time is counted only after a high level has been seen, so one long
  // low period yields a single edge.
  logic          armed;
  logic [FW-1:0] filt_cnt;
  logic          edge_acc;

  assign edge_acc = armed & ~ps2_clk_s & (filt_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      filt_cnt <= FW'(FILTER - 1);
    end else if (ps2_clk_s) begin
      armed    <= 1'b1;
      filt_cnt <= FW'(FILTER - 1);
    end else if (armed) begin
      if (filt_cnt == '0) armed <= 1'b0;
      else                filt_cnt <= filt_cnt - FW'(1);
    end
  end

  rx_state_t     state;
  rx_state_t     state_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_nxt;
  logic          par_ok;
  logic          par_ok_nxt;
  logic          push_nxt;
  logic          push_q;
  logic          perr_set;
  logic [TW-1:0] to_cnt;
  logic          to_expire;
  logic          en;

  assign to_expire = (state != IDLE) & (to_cnt == '0);

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    par_ok_nxt  = par_ok;
    push_nxt    = 1'b0;
    perr_set    = 1'b0;
    if (!en || to_expire) begin
      state_nxt = IDLE;
    end else if (edge_acc) begin
      case (state)
        IDLE: begin
          if (!ps2_data_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end
        end
        DATA: begin
          shift_nxt   = {ps2_data_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_ok_nxt = ^{shift, ps2_data_s};
          state_nxt  = STOP;
        end
        STOP: begin
          if (ps2_data_s && par_ok) push_nxt = 1'b1;
          else                      perr_set = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
      push_q  <= 1'b0;
      to_cnt  <= TW'(TIMEOUT - 1);
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_ok  <= par_ok_nxt;
      push_q  <= push_nxt;
      if (state == IDLE || edge_acc) to_cnt <= TW'(TIMEOUT - 1);
      else if (to_cnt != '0)         to_cnt <= to_cnt - TW'(1);
    end
  end

  // Bus side: reads pop and writes apply only once the access has ended.
  logic          rd_acc;
  logic          wr_acc;
  logic          rd_pend;
  logic          wr_pend;
  logic [1:0]    wr_addr;
  logic [2:0]    wr_ctrl;
  logic          wr_apply;
  logic          pop;
  logic          flush;
  logic          clr;
  logic          ovf;
  logic          perr;
  logic          ovf_set;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    status;
  logic [7:0]    rd_val;

  assign rd_acc   = ~cs_ & ~oe_;
  assign wr_acc   = ~cs_ & ~we_;
  assign pop      = rd_pend & ~rd_acc;
  assign wr_apply = wr_pend & ~wr_acc & (wr_addr == ADDR_CTRL);
  assign flush    = wr_apply & wr_ctrl[CTRL_FLUSH];
  assign clr      = wr_apply & wr_ctrl[CTRL_CLR];
  assign ovf_set  = push_q & fifo_full & ~pop & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_ctrl <= '0;
      en      <= 1'b1;
      ovf     <= 1'b0;
      perr    <= 1'b0;
    end else begin
      rd_pend <= rd_acc & (addr == ADDR_DATA);
      wr_pend <= wr_acc;
      if (wr_acc) begin
        wr_addr <= addr;
        wr_ctrl <= data[2:0];
      end
      if (wr_apply) en <= wr_ctrl[CTRL_EN];
      ovf  <= clr ? 1'b0 : (ovf | ovf_set);
      perr <= clr ? 1'b0 : (perr | perr_set);
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop),
    .flush (flush),
    .wdata (shift),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status                   = '0;
    status[ST_NE]            = ~fifo_empty;
    status[ST_FULL]          = fifo_full;
    status[ST_OVF]           = ovf;
    status[ST_PERR]          = perr;
    status[ST_CNT_LSB +: 4]  = 4'(fifo_count);
  end

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      ADDR_DATA:   rd_val = fifo_empty ? 8'h00 : fifo_head;
      ADDR_STATUS: rd_val = status;
      ADDR_CTRL:   rd_val = {7'b0, en};
      default:     rd_val = 8'h00;
    endcase
  end

  assign data     = (~cs_ & ~oe_ & we_) ? rd_val : 8'bz;
  assign kbd_irq_ = ~(~fifo_empty & en);

endmodule
